// File: rtl/dual_write_regfile_if.sv
// Purpose : bundles the register file's write-back, read and status signals.
// Latency : n/a (signal bundle only).
// Backpressure: none; write-back gates its own enables, no ready path exists.
//
// master : write-back + decode side (drives writes and read addresses).
// slave  : register file (returns read data, commit counter, collision flag).
interface dual_write_regfile_if #(
  parameter int CNT_W = 32
);
  // Write-back ports; slot 0 is program-order older than slot 1.
  logic             reg_write_enable0;
  logic [4:0]       reg_write_addr0;
  logic [31:0]      reg_write_data0;
  logic             reg_write_enable1;
  logic [4:0]       reg_write_addr1;
  logic [31:0]      reg_write_data1;
  // Decode read ports: source operands for issue slot 0 and slot 1.
  logic [4:0]       rs_addr0;
  logic [4:0]       rt_addr0;
  logic [4:0]       rs_addr1;
  logic [4:0]       rt_addr1;
  logic [31:0]      rs_data0;
  logic [31:0]      rt_data0;
  logic [31:0]      rs_data1;
  logic [31:0]      rt_data1;
  // Status for performance monitoring.
  logic [CNT_W-1:0] write_count;
  logic             write_conflict;

  modport master (
    output reg_write_enable0, reg_write_addr0, reg_write_data0,
    output reg_write_enable1, reg_write_addr1, reg_write_data1,
    output rs_addr0, rt_addr0, rs_addr1, rt_addr1,
    input  rs_data0, rt_data0, rs_data1, rt_data1,
    input  write_count, write_conflict
  );

  modport slave (
    input  reg_write_enable0, reg_write_addr0, reg_write_data0,
    input  reg_write_enable1, reg_write_addr1, reg_write_data1,
    input  rs_addr0, rt_addr0, rs_addr1, rt_addr1,
    output rs_data0, rt_data0, rs_data1, rt_data1,
    output write_count, write_conflict
  );
endinterface

// File: rtl/dual_write_regfile.sv
// Purpose : dual-write, quad-read MIPS architectural register file, $zero hard-wired.
// Latency : reads combinational with same-cycle write bypass; writes stored on next edge.
// Backpressure: none; every enabled write to a nonzero register commits.
//
// Ports: clk, rst (synchronous, active-low), rf (slave modport): two write-back
// ports, four read ports, write_count (committed nonzero writes), write_conflict.
module dual_write_regfile #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  dual_write_regfile_if.slave  rf
);
  localparam int AW = 5;

  // Register 0 has no storage; it always reads as zero.
  logic [31:0]      regs_q [1:NUM_REGS-1];
  logic [31:0]      regs_d [1:NUM_REGS-1];
  logic [CNT_W-1:0] write_count_q, write_count_d;
  logic             write_conflict_q, write_conflict_d;

  logic wr0_act, wr1_act;
  logic [AW-1:0] rd_addr [4];
  logic [31:0]   rd_data [4];

  // A write to $zero is dropped everywhere: storage, bypass, counter, conflict.
  assign wr0_act = rf.reg_write_enable0 && (rf.reg_write_addr0 != '0);
  assign wr1_act = rf.reg_write_enable1 && (rf.reg_write_addr1 != '0);

  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      // Port 1 is applied last so the younger slot wins a same-address collision.
      if (wr0_act && (rf.reg_write_addr0 == AW'(i))) regs_d[i] = rf.reg_write_data0;
      if (wr1_act && (rf.reg_write_addr1 == AW'(i))) regs_d[i] = rf.reg_write_data1;
    end
    write_count_d    = write_count_q + CNT_W'(wr0_act) + CNT_W'(wr1_act);
    write_conflict_d = wr0_act && wr1_act && (rf.reg_write_addr0 == rf.reg_write_addr1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
      write_count_q    <= '0;
      write_conflict_q <= 1'b0;
    end else begin
      regs_q           <= regs_d;
      write_count_q    <= write_count_d;
      write_conflict_q <= write_conflict_d;
    end
  end

  assign rd_addr[0] = rf.rs_addr0;
  assign rd_addr[1] = rf.rt_addr0;
  assign rd_addr[2] = rf.rs_addr1;
  assign rd_addr[3] = rf.rt_addr1;

  // Write-first read: in-flight write-back data beats storage, slot 1 beats slot 0.
  always_comb begin
    rd_data = '{default: '0};
    for (int p = 0; p < 4; p++) begin
      if (rd_addr[p] != '0) begin
        if (wr1_act && (rf.reg_write_addr1 == rd_addr[p])) begin
          rd_data[p] = rf.reg_write_data1;
        end else if (wr0_act && (rf.reg_write_addr0 == rd_addr[p])) begin
          rd_data[p] = rf.reg_write_data0;
        end else begin
          for (int i = 1; i < NUM_REGS; i++) begin
            if (rd_addr[p] == AW'(i)) rd_data[p] = regs_q[i];
          end
        end
      end
    end
  end

  assign rf.rs_data0       = rd_data[0];
  assign rf.rt_data0       = rd_data[1];
  assign rf.rs_data1       = rd_data[2];
  assign rf.rt_data1       = rd_data[3];
  assign rf.write_count    = write_count_q;
  assign rf.write_conflict = write_conflict_q;
endmodule

// File: tb/tb_dual_write_regfile.sv
// Purpose : self-checking bench for dual_write_regfile (directed table, corner sequences, random vs model).
// Latency : inputs driven at negedge, outputs sampled 1ns later, commits on posedge.
// Backpressure: none in the DUT; the bench drives one write set per cycle.
module tb_dual_write_regfile;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dual_write_regfile_if #(.CNT_W(32)) bus ();
  dual_write_regfile #(.NUM_REGS(32), .CNT_W(32)) dut (.clk(clk), .rst(rst), .rf(bus));

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra [4];
    logic [31:0] exp_rd [4];
    logic [31:0] exp_cnt;
    logic        exp_conf;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic set_wr(input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                        input logic we1, input logic [4:0] wa1, input logic [31:0] wd1);
    bus.reg_write_enable0 = we0; bus.reg_write_addr0 = wa0; bus.reg_write_data0 = wd0;
    bus.reg_write_enable1 = we1; bus.reg_write_addr1 = wa1; bus.reg_write_data1 = wd1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] a3);
    bus.rs_addr0 = a0; bus.rt_addr0 = a1; bus.rs_addr1 = a2; bus.rt_addr1 = a3;
  endtask

  function automatic logic [31:0] rdv(input int p);
    case (p)
      0:       return bus.rs_data0;
      1:       return bus.rt_data0;
      2:       return bus.rs_data1;
      default: return bus.rt_data1;
    endcase
  endfunction

  // Reference state for the random phase.
  logic [31:0] mdl [32];
  logic [31:0] nxt [32];
  logic [31:0] mcnt;
  logic        mconf;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed table; exp_cnt/exp_conf reflect rows already committed.
    vecs[0] = '{1'b1, 5'd5,  32'h1234_5678, 1'b0, 5'd0,  32'h0,
                '{5'd5, 5'd5, 5'd5, 5'd5},
                '{32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678}, 32'd0, 1'b0};
    vecs[1] = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0,  32'h0,
                '{5'd5, 5'd5, 5'd0, 5'd1},
                '{32'h1234_5678, 32'h1234_5678, 32'h0, 32'h0}, 32'd1, 1'b0};
    vecs[2] = '{1'b1, 5'd8,  32'hAAAA_AAAA, 1'b1, 5'd8,  32'h5555_5555,
                '{5'd8, 5'd8, 5'd8, 5'd5},
                '{32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 32'h1234_5678}, 32'd1, 1'b0};
    vecs[3] = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0,  32'h0,
                '{5'd8, 5'd8, 5'd8, 5'd8},
                '{32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555}, 32'd3, 1'b1};
    vecs[4] = '{1'b1, 5'd31, 32'd7, 1'b1, 5'd0,  32'hFFFF_FFFF,
                '{5'd0, 5'd31, 5'd0, 5'd8},
                '{32'h0, 32'd7, 32'h0, 32'h5555_5555}, 32'd3, 1'b0};
    vecs[5] = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0,  32'h0,
                '{5'd0, 5'd31, 5'd8, 5'd5},
                '{32'h0, 32'd7, 32'h5555_5555, 32'h1234_5678}, 32'd4, 1'b0};
    vecs[6] = '{1'b1, 5'd31, 32'd1, 1'b1, 5'd9,  32'd2,
                '{5'd31, 5'd9, 5'd31, 5'd0},
                '{32'd1, 32'd2, 32'd1, 32'h0}, 32'd4, 1'b0};
    vecs[7] = '{1'b0, 5'd9,  32'hDEAD_BEEF, 1'b0, 5'd31, 32'hBAD0_BAD0,
                '{5'd9, 5'd31, 5'd9, 5'd31},
                '{32'd2, 32'd1, 32'd2, 32'd1}, 32'd6, 1'b0};

    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_rd(5'd0, 5'd0, 5'd0, 5'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Reset state: every address on every port reads zero.
    #1;
    check("reset count", bus.write_count, 32'd0);
    check("reset conflict", {31'd0, bus.write_conflict}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      set_rd(5'(i), 5'(31 - i), 5'((i + 7) % 32), 5'((i + 16) % 32));
      #1;
      for (int p = 0; p < 4; p++) check($sformatf("reset rd a%0d p%0d", i, p), rdv(p), 32'h0);
    end

    // Directed table.
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      set_wr(vecs[v].we0, vecs[v].wa0, vecs[v].wd0, vecs[v].we1, vecs[v].wa1, vecs[v].wd1);
      set_rd(vecs[v].ra[0], vecs[v].ra[1], vecs[v].ra[2], vecs[v].ra[3]);
      #1;
      for (int p = 0; p < 4; p++) check($sformatf("vec%0d rd%0d", v, p), rdv(p), vecs[v].exp_rd[p]);
      check($sformatf("vec%0d count", v), bus.write_count, vecs[v].exp_cnt);
      check($sformatf("vec%0d conflict", v), {31'd0, bus.write_conflict}, {31'd0, vecs[v].exp_conf});
    end

    // Counter wrap: preload all-ones, then a dual nonzero write adds 2.
    @(negedge clk);
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    force dut.write_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.write_count_q;
    set_wr(1'b1, 5'd10, 32'h0000_0A0A, 1'b1, 5'd11, 32'h0000_0B0B);
    @(negedge clk);
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_rd(5'd10, 5'd11, 5'd10, 5'd11);
    #1;
    check("wrap count", bus.write_count, 32'd1);
    check("wrap conflict", {31'd0, bus.write_conflict}, 32'd0);
    check("wrap r10", bus.rs_data0, 32'h0000_0A0A);
    check("wrap r11", bus.rt_data0, 32'h0000_0B0B);

    // Reset beats write.
    @(negedge clk);
    set_wr(1'b1, 5'd3, 32'd9, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_rd(5'd3, 5'd4, 5'd3, 5'd4);
    #1;
    check("pre-reset r3", bus.rs_data0, 32'd9);
    rst = 1'b0;
    set_wr(1'b1, 5'd3, 32'd10, 1'b1, 5'd4, 32'd11);
    @(negedge clk);
    rst = 1'b1;
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    for (int p = 0; p < 4; p++) check($sformatf("post-reset rd%0d", p), rdv(p), 32'h0);
    check("post-reset count", bus.write_count, 32'd0);
    check("post-reset conflict", {31'd0, bus.write_conflict}, 32'd0);

    // Random phase against a model: the cycle's result is the old state with
    // writes applied in program order; reads see that result.
    for (int r = 0; r < 32; r++) mdl[r] = 32'h0;
    mcnt  = 32'd0;
    mconf = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic do_rst;
      logic we0, we1;
      logic [4:0] wa0, wa1;
      logic [31:0] wd0, wd1;
      logic [4:0] ra [4];
      int nw;
      @(negedge clk);
      do_rst = ($urandom_range(0, 49) == 0);
      we0 = ($urandom_range(0, 3) != 0);
      we1 = ($urandom_range(0, 3) != 0);
      wa0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      wa1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      wd0 = $urandom;
      wd1 = $urandom;
      for (int p = 0; p < 4; p++)
        ra[p] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      rst = !do_rst;
      set_wr(we0, wa0, wd0, we1, wa1, wd1);
      set_rd(ra[0], ra[1], ra[2], ra[3]);
      #1;
      nxt = mdl;
      nw  = 0;
      if (we0 && wa0 != 5'd0) begin nxt[wa0] = wd0; nw++; end
      if (we1 && wa1 != 5'd0) begin nxt[wa1] = wd1; nw++; end
      if (!do_rst)
        for (int p = 0; p < 4; p++) check($sformatf("rand%0d rd%0d", n, p), rdv(p), nxt[ra[p]]);
      check($sformatf("rand%0d count", n), bus.write_count, mcnt);
      check($sformatf("rand%0d conflict", n), {31'd0, bus.write_conflict}, {31'd0, mconf});
      if (do_rst) begin
        for (int r = 0; r < 32; r++) mdl[r] = 32'h0;
        mcnt  = 32'd0;
        mconf = 1'b0;
      end else begin
        mdl   = nxt;
        mcnt  = mcnt + 32'(nw);
        mconf = (nw == 2) && (wa0 == wa1);
      end
    end

    @(negedge clk);
    rst = 1'b1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/dual_write_regfile.md
# dual_write_regfile

Architectural register file for the dual-issue MIPS pipeline. It is the receiving end of the two write-back ports: it accepts up to two register writes per cycle from write-back and serves four combinational read ports to decode, two source operands for each issue slot. Same-cycle writes are bypassed to readers, `$zero` is hard-wired, and a committed-write counter plus a same-address collision flag support the bench and performance monitoring.

## Interface
- `NUM_REGS`, 32: architectural registers; address width is 5 bits (`MipsReg`).
- `CNT_W`, 32: width of the committed-write counter.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `reg_write_enable0` / `reg_write_enable1`  in  1  write enable, slot 0 (older) and slot 1 (younger).
- `reg_write_addr0` / `reg_write_addr1`  in  5  destination register.
- `reg_write_data0` / `reg_write_data1`  in  32  write data.
- `rs_addr0`, `rt_addr0`, `rs_addr1`, `rt_addr1`  in  5  read addresses, slot 0 and slot 1 sources.
- `rs_data0`, `rt_data0`, `rs_data1`, `rt_data1`  out  32  read data, combinational.
- `write_count`  out  CNT_W  number of committed writes to nonzero registers since reset.
- `write_conflict`  out  1  registered flag: both ports wrote the same nonzero register in the previous cycle.

## Operation
- Storage is 31 registers of 32 bits (1..31). Register 0 is not stored.
- Commit at each rising edge with `rst`=1:
  - Port 0 writes `reg_write_data0` to `reg_write_addr0` when `reg_write_enable0`=1 and the address is not 0.
  - Port 1 writes the same way using its own signals.
  - If both ports target the same nonzero address, port 1 wins, because slot 1 is program-order younger.
- Read path, evaluated per read port in priority order:
  1. Address 0 reads 0, regardless of any write to 0.
  2. Otherwise, if port 1 is writing this address this cycle, return `reg_write_data1`.
  3. Otherwise, if port 0 is writing this address this cycle, return `reg_write_data0`.
  4. Otherwise, return the stored value.
- The read path is write-first: decode sees same-cycle write-back data with zero-cycle latency.
- `write_count` increments by the number of enabled writes to nonzero addresses in the cycle: 0, 1 or 2.
  - A same-address collision still counts 2, because both instructions retired.
  - The counter wraps modulo 2^CNT_W.
- `write_conflict` is set on the next edge when both enables are 1 and both addresses are equal and nonzero; it is cleared otherwise. It is a one-cycle pulse per colliding cycle.
- `x`/`z` on a disabled port's address or data has no effect on any output.

## Timing
- Reset (`rst`=0 at an edge):
  - All stored registers become 0; `write_count` becomes 0; `write_conflict` becomes 0.
  - Writes presented in that cycle are discarded. Reset beats write.
- Reset mid-operation behaves identically; there is no multi-cycle clear sequence.
- During a reset cycle the read ports still bypass the presented writes combinationally. Decode is flushed during reset, so these values are don't-care.
- Write latency: data presented in cycle N is visible through bypass in cycle N and from storage from cycle N+1 on.
- `write_count` and `write_conflict` reflect cycle-N writes in cycle N+1.
- There is no handshake and no stall input. Write-back already gates enables with stall/flush/valid, and this block commits every enabled write.
- The read paths contain no combinational loop; read addresses may depend on other read data only through external logic.

## Test plan
- Reset, then read all 32 addresses on the four ports -> every read is 0; `write_count`=0; `write_conflict`=0.
- Port 0 writes r5=0x1234_5678 in cycle N -> `rs_data0` with `rs_addr0`=5 returns 0x1234_5678 in cycle N (bypass) and in N+1 (storage); `write_count`=1 in N+1.
- Both ports write r8 (port 0: 0xAAAA_AAAA, port 1: 0x5555_5555) -> all readers of r8 return 0x5555_5555 in the same cycle and afterwards; `write_conflict`=1 for exactly one cycle; `write_count` +2.
- Port 1 writes r0=0xFFFF_FFFF while port 0 writes r31=7 -> r0 reads 0 in both cycles; r31 reads 7; `write_count` +1; no conflict.
- Preload `write_count` to 0xFFFF_FFFF by forcing it, then perform a dual nonzero write -> `write_count`=1.
- Write r3=9, then assert `rst`=0 in the same cycle as writes of r3=10 and r4=11 -> after the edge r3=0, r4=0, `write_count`=0.
